// File: rtl/matrix_row_deskewer.sv
// Reassembles N beats of a 2N-1 lane skewed vector into an NxN matrix (row or column mode).
// Optional out-of-window lane checking is enabled with `define DESKEW_LANE_CHECK_EN.
module matrix_row_deskewer #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT_LEN  = 2 * N - 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  row_sel,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [0:SHIFT_LEN-1][DATA_WIDTH-1:0]  in_data,
    input  logic [0:SHIFT_LEN-1]                  valid_bits_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]   out_matrix,
    output logic [0:N-1][0:N-1]                   out_valid_bits,
    output logic                                  lane_err,
    output logic                                  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready and out_valid depend only on state, never combinationally on the inputs.
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(SHIFT_LEN);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                          state, state_d;
    logic [BW-1:0]                   beat;
    logic                            mode_q;
    logic                            accept;
    logic                            last_beat;
    logic                            eff_mode;
    logic [0:N-1][DATA_WIDTH-1:0]    win_data;
    logic [0:N-1]                    win_vb;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign state_dbg = state;
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat == BW'(N - 1));
    // Beat 0 uses the live row_sel; later beats use the value latched on beat 0.
    assign eff_mode  = (beat == '0) ? row_sel : mode_q;

    always_comb begin
        win_data = '0;
        win_vb   = '0;
        for (int i = 0; i < N; i++) begin
            win_data[i] = in_data[LW'(beat) + LW'(i)];
            win_vb[i]   = valid_bits_in[LW'(beat) + LW'(i)];
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            COLLECT: if (accept && last_beat) state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= COLLECT;
            beat           <= '0;
            mode_q         <= 1'b1;
            out_matrix     <= '0;
            out_valid_bits <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                beat <= last_beat ? '0 : beat + 1'b1;
                if (beat == '0) mode_q <= row_sel;
                for (int i = 0; i < N; i++) begin
                    if (eff_mode) begin
                        out_matrix[beat][BW'(i)]     <= win_data[i];
                        out_valid_bits[beat][BW'(i)] <= win_vb[i];
                    end else begin
                        out_matrix[BW'(i)][beat]     <= win_data[i];
                        out_valid_bits[BW'(i)][beat] <= win_vb[i];
                    end
                end
            end
        end
    end

`ifdef DESKEW_LANE_CHECK_EN
    logic oow_nz;

    // Any nonzero lane outside the current beat's window k..k+N-1 is a skew error.
    always_comb begin
        oow_nz = 1'b0;
        for (int j = 0; j < SHIFT_LEN; j++) begin
            if (((j < int'(beat)) || (j >= int'(beat) + N)) && (in_data[j] != '0))
                oow_nz = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    lane_err <= 1'b0;
        else if (accept && oow_nz)  lane_err <= 1'b1;
    end
`else
    assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_row_deskewer.sv
// Bench for matrix_row_deskewer (N=3, DATA_WIDTH=8): directed scenarios plus random frames
// checked against a matrix model derived from the beat/lane placement rules.
module tb_matrix_row_deskewer;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int SL = 2 * N - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       row_sel = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [0:SL-1][DW-1:0]      in_data = '0;
  logic [0:SL-1]              valid_bits_in = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [0:N-1][0:N-1][DW-1:0] out_matrix;
  logic [0:N-1][0:N-1]        out_valid_bits;
  logic                       lane_err;
  logic                       state_dbg;

  matrix_row_deskewer #(.N(N), .DATA_WIDTH(DW), .SHIFT_LEN(SL)) dut (
    .clk(clk), .rst(rst), .row_sel(row_sel), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .valid_bits_in(valid_bits_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_matrix(out_matrix), .out_valid_bits(out_valid_bits),
    .lane_err(lane_err), .state_dbg(state_dbg)
  );

  // scoreboard
  logic [N*N*DW-1:0] exp_q[$];
  logic [N*N-1:0]    exp_vb_q[$];
  logic [DW-1:0]     fr_data[N][SL];
  logic              fr_vb[N][SL];
  bit                err_exp = 1'b0;
  int                checks = 0;
  int                errors = 0;

  // driver tasks
  task automatic gen_frame(input bit garbage, input bit rand_vb);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < SL; j++) begin
        if (j >= k && j < k + N) begin
          fr_data[k][j] = DW'($urandom_range(0, 255));
          fr_vb[k][j]   = rand_vb ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
          fr_data[k][j] = garbage ? DW'($urandom_range(1, 255)) : '0;
          fr_vb[k][j]   = 1'($urandom_range(0, 1));
        end
      end
  endtask

  task automatic load_spec_frame();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < SL; j++) begin
        fr_data[k][j] = (j >= k && j < k + N) ? DW'(3 * k + (j - k) + 1) : '0;
        fr_vb[k][j]   = 1'b1;
      end
  endtask

  // Element (r,c): row mode takes beat r at offset c; column mode takes beat c at offset r.
  task automatic push_expect(input bit mode);
    logic [0:N-1][0:N-1][DW-1:0] em;
    logic [0:N-1][0:N-1]         ev;
    int b, off;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        b   = mode ? r : c;
        off = mode ? c : r;
        em[r][c] = fr_data[b][b + off];
        ev[r][c] = fr_vb[b][b + off];
      end
    exp_q.push_back(em);
    exp_vb_q.push_back(ev);
  endtask

  task automatic set_lanes(input int k);
    for (int j = 0; j < SL; j++) begin
      in_data[j]       = fr_data[k][j];
      valid_bits_in[j] = fr_vb[k][j];
    end
  endtask

  task automatic note_lane_err(input int k);
`ifdef DESKEW_LANE_CHECK_EN
    for (int j = 0; j < SL; j++)
      if ((j < k || j >= k + N) && fr_data[k][j] != '0) err_exp = 1'b1;
`endif
  endtask

  task automatic send_beat(input int k, input bit rs, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    set_lanes(k);
    row_sel  = rs;
    in_valid = 1'b1;
    @(posedge clk);
    note_lane_err(k);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic check_frame(input string name);
    logic [N*N*DW-1:0] em;
    logic [N*N-1:0]    ev;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid: got %b want 1", name, out_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: got empty queue want 1 frame", name);
    end else begin
      em = exp_q.pop_front();
      ev = exp_vb_q.pop_front();
      if (out_matrix !== em) begin
        errors++; $display("FAIL %s out_matrix: got %h want %h", name, out_matrix, em);
      end
      checks++;
      if (out_valid_bits !== ev) begin
        errors++; $display("FAIL %s out_valid_bits: got %b want %b", name, out_valid_bits, ev);
      end
    end
    checks++;
    if (lane_err !== err_exp) begin
      errors++; $display("FAIL %s lane_err: got %b want %b", name, lane_err, err_exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    err_exp = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lane_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got out_valid=%b in_ready=%b lane_err=%b want 0/1/0",
               out_valid, in_ready, lane_err);
    end
    checks++;
    if (out_matrix !== '0 || out_valid_bits !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%b want all zero", out_matrix, out_valid_bits);
    end
  endtask

  task automatic test_row_fixed();
    load_spec_frame();
    push_expect(1'b1);
    send_beat(0, 1'b1, 0);
    send_beat(1, 1'b1, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL row_latency: got out_valid=%b want 0 after 2 beats", out_valid);
    end
    send_beat(2, 1'b1, 0);
    checks++;
    if (out_matrix[2][0] !== 8'd7 || out_matrix[1][2] !== 8'd6) begin
      errors++;
      $display("FAIL row_elem: got [2][0]=%0d [1][2]=%0d want 7 6", out_matrix[2][0], out_matrix[1][2]);
    end
    check_frame("row_fixed");
  endtask

  task automatic test_col_fixed();
    load_spec_frame();
    push_expect(1'b0);
    for (int k = 0; k < N; k++) send_beat(k, 1'b0, 0);
    checks++;
    if (out_matrix[0][1] !== 8'd4 || out_matrix[2][1] !== 8'd6) begin
      errors++;
      $display("FAIL col_elem: got [0][1]=%0d [2][1]=%0d want 4 6", out_matrix[0][1], out_matrix[2][1]);
    end
    check_frame("col_fixed");
  endtask

  task automatic test_backpressure();
    logic [N*N*DW-1:0] held;
    gen_frame(1'b0, 1'b1);
    push_expect(1'b1);
    for (int k = 0; k < N; k++) send_beat(k, 1'b1, 0);
    held = exp_q[0];
    gen_frame(1'b0, 1'b1);
    set_lanes(0);
    row_sel  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_matrix !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: got in_ready=%b out_valid=%b m=%h want 0/1/%h",
                 c, in_ready, out_valid, out_matrix, held);
      end
    end
    void'(exp_q.pop_front());
    void'(exp_vb_q.pop_front());
    push_expect(1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    note_lane_err(0);
    #1;
    in_valid = 1'b0;
    send_beat(1, 1'b0, 0);
    send_beat(2, 1'b1, 0);
    check_frame("bp_next");
  endtask

  task automatic test_gaps_mode(input bit m);
    gen_frame(1'b0, 1'b0);
    fr_vb[1][3] = 1'b0;
    push_expect(m);
    send_beat(0, m, 0);
    send_beat(1, ~m, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_partial: got out_valid=%b want 0", out_valid);
    end
    send_beat(2, ~m, 1);
    checks++;
    if ((m ? out_valid_bits[1][2] : out_valid_bits[2][1]) !== 1'b0) begin
      errors++; $display("FAIL gap_vb: got lane3 beat1 bit=1 want 0 (mode %b)", m);
    end
    check_frame(m ? "gaps_row" : "gaps_col");
  endtask

  task automatic test_reset_mid();
    bit m;
    gen_frame(1'b0, 1'b1);
    send_beat(0, 1'b1, 0);
    send_beat(1, 1'b1, 0);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_matrix !== '0 || out_valid_bits !== '0) begin
      errors++;
      $display("FAIL reset_mid: got out_valid=%b in_ready=%b m=%h want 0/1/0", out_valid, in_ready, out_matrix);
    end
    m = 1'($urandom_range(0, 1));
    gen_frame(1'b0, 1'b1);
    push_expect(m);
    for (int k = 0; k < N; k++) send_beat(k, m, 0);
    check_frame("reset_fresh");
  endtask

  task automatic test_lane_err();
    do_reset();
    gen_frame(1'b0, 1'b1);
    fr_data[0][4] = 8'hAA;
    push_expect(1'b1);
    send_beat(0, 1'b1, 0);
    checks++;
    if (lane_err !== err_exp) begin
      errors++; $display("FAIL lane_err_set: got %b want %b", lane_err, err_exp);
    end
    send_beat(1, 1'b1, 0);
    send_beat(2, 1'b1, 0);
    check_frame("lane_err_frame");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lane_err !== err_exp) begin
      errors++; $display("FAIL lane_err_sticky: got %b want %b", lane_err, err_exp);
    end
    do_reset();
    checks++;
    if (lane_err !== 1'b0) begin
      errors++; $display("FAIL lane_err_clear: got %b want 0", lane_err);
    end
  endtask

  task automatic test_random();
    bit m;
    for (int f = 0; f < 20; f++) begin
      m = 1'($urandom_range(0, 1));
      gen_frame($urandom_range(0, 3) == 0, 1'b1);
      push_expect(m);
      for (int k = 0; k < N; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        send_beat(k, (k == 0) ? m : 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      check_frame("random");
    end
  endtask

  initial begin
    test_reset();
    test_row_fixed();
    test_col_fixed();
    test_backpressure();
    test_gaps_mode(1'b1);
    test_gaps_mode(1'b0);
    test_reset_mid();
    test_lane_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
